// File: rtl/hqa_pkg.sv
// Shared types and widths for the homography query arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package hqa_pkg;

  localparam int COORD_W = 10;
  localparam int R_W     = 5;
  localparam int G_W     = 6;
  localparam int B_W     = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FULL  = 2'd2,
    S_DRAIN = 2'd3
  } hqa_state_e;

  // One in-flight query: owner is 1 for the CCD requester, 0 for DVI.
  typedef struct packed {
    logic               owner;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } hqa_tag_t;

  localparam int TAG_W = $bits(hqa_tag_t);

endpackage

// File: rtl/hqa_tag_fifo.sv
// In-order tag store for outstanding engine queries; DEPTH entries of WIDTH bits.
// Latency: head entry visible combinationally; push lands one cycle later.
// Backpressure: push ignored when full, pop ignored when empty; push+pop allowed together.
module hqa_tag_fifo #(
  parameter int DEPTH = 5,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem_q[rd_ptr_q];

  // Next pointers, occupancy and storage contents.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
  end

  // State register; reset discards every stored tag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/homography_query_arbiter.sv
// Round-robin sharing of one homography engine between DVI (req0) and CCD (req1); macro HQA_COORD_CHECK_EN adds return-coordinate checking.
// Latency: grant -> start 1 cycle; ready -> resp*_val 1 cycle.
// Backpressure: requesters hold valid until granted; no grants when MAX_OUTSTANDING queries are in flight or while flushing.
module homography_query_arbiter
  import hqa_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 5
) (
  input  logic               clk_25,
  input  logic               rst_n,
  input  logic               req0_valid,
  input  logic [COORD_W-1:0] req0_x,
  input  logic [COORD_W-1:0] req0_y,
  input  logic               req1_valid,
  input  logic [COORD_W-1:0] req1_x,
  input  logic [COORD_W-1:0] req1_y,
  output logic               req0_grant,
  output logic               req1_grant,
  input  logic               flush,
  output logic               flush_done,
  output logic [COORD_W-1:0] query_x,
  output logic [COORD_W-1:0] query_y,
  output logic               start,
  input  logic               ready,
  input  logic [COORD_W-1:0] return_x,
  input  logic [COORD_W-1:0] return_y,
  input  logic [R_W-1:0]     r,
  input  logic [G_W-1:0]     g,
  input  logic [B_W-1:0]     b,
  output logic               resp0_val,
  output logic               resp1_val,
  output logic [COORD_W-1:0] resp_x,
  output logic [COORD_W-1:0] resp_y,
  output logic [R_W-1:0]     resp_r,
  output logic [G_W-1:0]     resp_g,
  output logic [B_W-1:0]     resp_b,
  output logic [2:0]         outstanding,
  output logic               err_underflow,
  output logic               mismatch
);

`ifdef HQA_COORD_CHECK_EN
  localparam int FIFO_W = TAG_W;
`else
  localparam int FIFO_W = 1;
`endif
  localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);

  hqa_state_e         state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               last_q, last_d;          // 1: req1 took the previous grant
  logic [COORD_W-1:0] query_x_q, query_x_d, query_y_q, query_y_d;
  logic               start_q, start_d;
  logic               resp0_val_q, resp0_val_d, resp1_val_q, resp1_val_d;
  logic [COORD_W-1:0] resp_x_q, resp_x_d, resp_y_q, resp_y_d;
  logic [R_W-1:0]     resp_r_q, resp_r_d;
  logic [G_W-1:0]     resp_g_q, resp_g_d;
  logic [B_W-1:0]     resp_b_q, resp_b_d;
  logic               err_q, err_d;
  logic               flush_done_q, flush_done_d;
  logic               done_seen_q, done_seen_d; // flush_done already pulsed this flush
  logic               can_issue, gnt0, gnt1, push, pop, pop_owner;
  logic               tag_full, tag_empty;
  logic [FIFO_W-1:0]  push_dat, pop_dat;

  // Round-robin grant, gated by the registered state only.
  always_comb begin
    can_issue = ((state_q == S_IDLE) || (state_q == S_RUN)) && !flush && !tag_full;
    gnt0      = can_issue && req0_valid && (!req1_valid || last_q);
    gnt1      = can_issue && req1_valid && (!req0_valid || !last_q);
  end

  assign push = gnt0 || gnt1;
  assign pop  = ready && !tag_empty;

`ifdef HQA_COORD_CHECK_EN
  hqa_tag_t push_tag, pop_tag;
  logic     mismatch_q, mismatch_d;

  assign push_tag  = gnt1 ? '{owner: 1'b1, x: req1_x, y: req1_y}
                          : '{owner: 1'b0, x: req0_x, y: req0_y};
  assign push_dat  = push_tag;
  assign pop_tag   = hqa_tag_t'(pop_dat);
  assign pop_owner = pop_tag.owner;

  // Sticky flag: engine echoed different coordinates than were issued.
  always_comb begin
    mismatch_d = mismatch_q;
    if (pop && ((return_x != pop_tag.x) || (return_y != pop_tag.y))) mismatch_d = 1'b1;
  end

  // Mismatch flag register.
  always_ff @(posedge clk_25) begin
    if (!rst_n) mismatch_q <= 1'b0;
    else        mismatch_q <= mismatch_d;
  end

  assign mismatch = mismatch_q;
`else
  assign push_dat  = gnt1;
  assign pop_owner = pop_dat[0];
  assign mismatch  = 1'b0;
`endif

  hqa_tag_fifo #(.DEPTH(MAX_OUTSTANDING), .WIDTH(FIFO_W)) u_tag_fifo (
    .clk      (clk_25),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .pop_dat  (pop_dat),
    .full     (tag_full),
    .empty    (tag_empty)
  );

  // Credit count, query/response datapath and flag next values.
  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 3'd1;
    else if (!push && pop) cnt_d = cnt_q - 3'd1;
    last_d      = gnt1 ? 1'b1 : (gnt0 ? 1'b0 : last_q);
    start_d     = push;
    query_x_d   = query_x_q;
    query_y_d   = query_y_q;
    if (gnt0) begin
      query_x_d = req0_x;
      query_y_d = req0_y;
    end else if (gnt1) begin
      query_x_d = req1_x;
      query_y_d = req1_y;
    end
    resp0_val_d = pop && !pop_owner;
    resp1_val_d = pop && pop_owner;
    resp_x_d    = pop ? return_x : resp_x_q;
    resp_y_d    = pop ? return_y : resp_y_q;
    resp_r_d    = pop ? r : resp_r_q;
    resp_g_d    = pop ? g : resp_g_q;
    resp_b_d    = pop ? b : resp_b_q;
    err_d       = err_q || (ready && tag_empty);
    // Drain is complete once the registered count is zero under flush.
    flush_done_d = flush && (cnt_q == 3'd0) && !done_seen_q;
    done_seen_d  = flush && (done_seen_q || flush_done_d);
  end

  // Next-state: follows the post-update count, with flush forcing drain.
  always_comb begin
    state_d = state_q;
    if (cnt_d == 3'd0)        state_d = S_IDLE;
    else if (flush)           state_d = S_DRAIN;
    else if (cnt_d == MAX_CNT) state_d = S_FULL;
    else                      state_d = S_RUN;
  end

  // FSM state register.
  always_ff @(posedge clk_25) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath and flag registers.
  always_ff @(posedge clk_25) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      last_q       <= 1'b1;
      query_x_q    <= '0;
      query_y_q    <= '0;
      start_q      <= 1'b0;
      resp0_val_q  <= 1'b0;
      resp1_val_q  <= 1'b0;
      resp_x_q     <= '0;
      resp_y_q     <= '0;
      resp_r_q     <= '0;
      resp_g_q     <= '0;
      resp_b_q     <= '0;
      err_q        <= 1'b0;
      flush_done_q <= 1'b0;
      done_seen_q  <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      query_x_q    <= query_x_d;
      query_y_q    <= query_y_d;
      start_q      <= start_d;
      resp0_val_q  <= resp0_val_d;
      resp1_val_q  <= resp1_val_d;
      resp_x_q     <= resp_x_d;
      resp_y_q     <= resp_y_d;
      resp_r_q     <= resp_r_d;
      resp_g_q     <= resp_g_d;
      resp_b_q     <= resp_b_d;
      err_q        <= err_d;
      flush_done_q <= flush_done_d;
      done_seen_q  <= done_seen_d;
    end
  end

  assign req0_grant    = gnt0;
  assign req1_grant    = gnt1;
  assign query_x       = query_x_q;
  assign query_y       = query_y_q;
  assign start         = start_q;
  assign resp0_val     = resp0_val_q;
  assign resp1_val     = resp1_val_q;
  assign resp_x        = resp_x_q;
  assign resp_y        = resp_y_q;
  assign resp_r        = resp_r_q;
  assign resp_g        = resp_g_q;
  assign resp_b        = resp_b_q;
  assign outstanding   = cnt_q;
  assign err_underflow = err_q;
  assign flush_done    = flush_done_q;

endmodule

// File: tb/tb_homography_query_arbiter.sv
// Directed bench for homography_query_arbiter: vector table plus flush/reset/underflow sequences.
// Latency: checks grants mid-cycle, registered outputs 1 time unit after each rising edge.
// Backpressure: engine returns are driven by hand to hold off or release the credit count.
module tb_homography_query_arbiter;
  import hqa_pkg::*;

  logic               clk_25 = 1'b0;
  logic               rst_n;
  logic               req0_valid, req1_valid, flush, ready;
  logic [COORD_W-1:0] req0_x, req0_y, req1_x, req1_y, return_x, return_y;
  logic [R_W-1:0]     r;
  logic [G_W-1:0]     g;
  logic [B_W-1:0]     b;
  logic               req0_grant, req1_grant, flush_done, start;
  logic [COORD_W-1:0] query_x, query_y, resp_x, resp_y;
  logic               resp0_val, resp1_val, err_underflow, mismatch;
  logic [R_W-1:0]     resp_r;
  logic [G_W-1:0]     resp_g;
  logic [B_W-1:0]     resp_b;
  logic [2:0]         outstanding;

  int checks   = 0;
  int failures = 0;

  always #20 clk_25 = ~clk_25;

  homography_query_arbiter #(.MAX_OUTSTANDING(5)) dut (
    .clk_25(clk_25), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_x(req0_x), .req0_y(req0_y),
    .req1_valid(req1_valid), .req1_x(req1_x), .req1_y(req1_y),
    .req0_grant(req0_grant), .req1_grant(req1_grant),
    .flush(flush), .flush_done(flush_done),
    .query_x(query_x), .query_y(query_y), .start(start),
    .ready(ready), .return_x(return_x), .return_y(return_y),
    .r(r), .g(g), .b(b),
    .resp0_val(resp0_val), .resp1_val(resp1_val),
    .resp_x(resp_x), .resp_y(resp_y),
    .resp_r(resp_r), .resp_g(resp_g), .resp_b(resp_b),
    .outstanding(outstanding), .err_underflow(err_underflow), .mismatch(mismatch)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_25);
    #1;
  endtask

  typedef struct {
    logic         v0;
    logic [9:0]   x0, y0;
    logic         v1;
    logic         rdy;
    logic [9:0]   rx, ry;
    logic         eg0, eg1, est, er0, er1;
    logic [2:0]   eout;
    logic [9:0]   eqx;
  } vec_t;

  function automatic vec_t mk(input logic v0, input logic [9:0] x0, input logic [9:0] y0,
                              input logic v1, input logic rdy, input logic [9:0] rx,
                              input logic [9:0] ry, input logic eg0, input logic eg1,
                              input logic est, input logic er0, input logic er1,
                              input logic [2:0] eout, input logic [9:0] eqx);
    vec_t v;
    v.v0 = v0; v.x0 = x0; v.y0 = y0; v.v1 = v1; v.rdy = rdy; v.rx = rx; v.ry = ry;
    v.eg0 = eg0; v.eg1 = eg1; v.est = est; v.er0 = er0; v.er1 = er1; v.eout = eout; v.eqx = eqx;
    return v;
  endfunction

  localparam int NV = 20;
  vec_t vt [NV];
  logic exp_mm;

  initial begin
    // req1 always presents (30,40); req0 presents x0/y0 from the table.
    //            v0 x0  y0  v1 rdy rx  ry   g0 g1 st r0 r1 out qx
    vt[0]  = mk(1, 10, 20, 1, 0,  0,  0,  1, 0, 1, 0, 0, 1, 10);
    vt[1]  = mk(1, 10, 20, 1, 0,  0,  0,  0, 1, 1, 0, 0, 2, 30);
    vt[2]  = mk(1, 10, 20, 1, 0,  0,  0,  1, 0, 1, 0, 0, 3, 10);
    vt[3]  = mk(1, 10, 20, 1, 0,  0,  0,  0, 1, 1, 0, 0, 4, 30);
    vt[4]  = mk(1, 10, 20, 1, 0,  0,  0,  1, 0, 1, 0, 0, 5, 10);
    vt[5]  = mk(1, 10, 20, 1, 0,  0,  0,  0, 0, 0, 0, 0, 5, 0);
    vt[6]  = mk(1, 10, 20, 1, 1, 10, 20,  0, 0, 0, 1, 0, 4, 0);
    vt[7]  = mk(1, 10, 20, 1, 0,  0,  0,  0, 1, 1, 0, 0, 5, 30);
    vt[8]  = mk(0, 10, 20, 0, 1, 30, 40,  0, 0, 0, 0, 1, 4, 0);
    vt[9]  = mk(0, 10, 20, 0, 1, 10, 20,  0, 0, 0, 1, 0, 3, 0);
    vt[10] = mk(0, 10, 20, 0, 1, 30, 40,  0, 0, 0, 0, 1, 2, 0);
    vt[11] = mk(0, 10, 20, 1, 1, 10, 20,  0, 1, 1, 1, 0, 2, 30);
    vt[12] = mk(0, 10, 20, 0, 1, 30, 40,  0, 0, 0, 0, 1, 1, 0);
    vt[13] = mk(0, 10, 20, 0, 1, 30, 40,  0, 0, 0, 0, 1, 0, 0);
    vt[14] = mk(0, 10, 20, 0, 0,  0,  0,  0, 0, 0, 0, 0, 0, 0);
    vt[15] = mk(1, 12, 34, 0, 0,  0,  0,  1, 0, 1, 0, 0, 1, 12);
    vt[16] = mk(0, 12, 34, 0, 0,  0,  0,  0, 0, 0, 0, 0, 1, 0);
    vt[17] = mk(0, 12, 34, 0, 0,  0,  0,  0, 0, 0, 0, 0, 1, 0);
    vt[18] = mk(0, 12, 34, 0, 1, 12, 34,  0, 0, 0, 1, 0, 0, 0);
    vt[19] = mk(0, 12, 34, 0, 0,  0,  0,  0, 0, 0, 0, 0, 0, 0);

    rst_n = 1'b0; req0_valid = 0; req1_valid = 0; flush = 0; ready = 0;
    req0_x = 0; req0_y = 0; req1_x = 30; req1_y = 40; return_x = 0; return_y = 0;
    r = 0; g = 0; b = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_outstanding", outstanding, 0);
    chk("rst_start", start, 0);
    chk("rst_resp_val", {resp0_val, resp1_val}, 0);
    chk("rst_err", err_underflow, 0);
    chk("rst_flush_done", flush_done, 0);
    chk("rst_query_x", query_x, 0);
    chk("rst_state", 32'(dut.state_q), 32'(S_IDLE));

    for (int i = 0; i < NV; i++) begin
      req0_valid = vt[i].v0; req0_x = vt[i].x0; req0_y = vt[i].y0;
      req1_valid = vt[i].v1; ready = vt[i].rdy;
      return_x = vt[i].rx; return_y = vt[i].ry;
      r = 5'(i); g = 6'(i + 1); b = 5'(i + 2);
      @(negedge clk_25);
      chk($sformatf("v%0d_grant0", i), req0_grant, vt[i].eg0);
      chk($sformatf("v%0d_grant1", i), req1_grant, vt[i].eg1);
      tick();
      chk($sformatf("v%0d_start", i), start, vt[i].est);
      chk($sformatf("v%0d_resp0_val", i), resp0_val, vt[i].er0);
      chk($sformatf("v%0d_resp1_val", i), resp1_val, vt[i].er1);
      chk($sformatf("v%0d_outstanding", i), outstanding, vt[i].eout);
      if (vt[i].est) chk($sformatf("v%0d_query_x", i), query_x, vt[i].eqx);
      if (vt[i].er0 || vt[i].er1) begin
        chk($sformatf("v%0d_resp_x", i), resp_x, vt[i].rx);
        chk($sformatf("v%0d_resp_y", i), resp_y, vt[i].ry);
        chk($sformatf("v%0d_resp_rgb", i), {resp_r, resp_g, resp_b},
            {5'(i), 6'(i + 1), 5'(i + 2)});
      end
      if (i == 5) chk("v5_state_full", 32'(dut.state_q), 32'(S_FULL));
    end
    chk("query_y_last", query_y, 34);

    // Flush with three queries outstanding.
    req0_valid = 1; req0_x = 7; req0_y = 8; req1_valid = 0; ready = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_25);
      chk($sformatf("fl_issue%0d", k), req0_grant, 1);
      tick();
    end
    chk("fl_out3", outstanding, 3);
    flush = 1;
    @(negedge clk_25);
    chk("fl_nogrant0", req0_grant, 0);
    tick();
    chk("fl_state_drain", 32'(dut.state_q), 32'(S_DRAIN));
    chk("fl_start_off", start, 0);
    ready = 1; return_x = 7; return_y = 8;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_25);
      chk($sformatf("fl_nogrant_d%0d", k), req0_grant, 0);
      tick();
      chk($sformatf("fl_resp%0d", k), resp0_val, 1);
      chk($sformatf("fl_done_early%0d", k), flush_done, 0);
      chk($sformatf("fl_out_d%0d", k), outstanding, 2 - k);
    end
    ready = 0;
    @(negedge clk_25);
    chk("fl_nogrant_idle", req0_grant, 0);
    tick();
    chk("fl_done_pulse", flush_done, 1);
    tick();
    chk("fl_done_clear", flush_done, 0);
    flush = 0;
    @(negedge clk_25);
    chk("fl_resume_grant", req0_grant, 1);
    tick();
    chk("fl_resume_start", start, 1);
    req0_valid = 0; ready = 1;
    tick();
    chk("fl_resume_out", outstanding, 0);
    ready = 0;

    // Flush with nothing outstanding.
    flush = 1;
    tick();
    chk("fl0_done", flush_done, 1);
    tick();
    chk("fl0_done_once", flush_done, 0);
    flush = 0;
    chk("mismatch_clean", mismatch, 0);
    chk("err_clean", err_underflow, 0);

    // Reset mid-operation discards tags; a later return is an underflow.
    req1_valid = 1; req1_x = 5; req1_y = 7;
    tick(); tick();
    chk("mid_out2", outstanding, 2);
    req1_valid = 0; rst_n = 0;
    tick();
    rst_n = 1;
    chk("mid_rst_out", outstanding, 0);
    ready = 1; return_x = 5; return_y = 7;
    tick();
    chk("uf_no_resp", {resp0_val, resp1_val}, 0);
    chk("uf_err", err_underflow, 1);
    chk("uf_out", outstanding, 0);
    ready = 0;

    // Issued (5,7), engine echoes (5,6).
    req1_valid = 1;
    tick();
    req1_valid = 0; ready = 1; return_x = 5; return_y = 6;
    tick();
    ready = 0;
    chk("mm_resp1", resp1_val, 1);
`ifdef HQA_COORD_CHECK_EN
    exp_mm = 1'b1;
`else
    exp_mm = 1'b0;
`endif
    chk("mm_flag", mismatch, exp_mm);
    tick();
    chk("mm_sticky", mismatch, exp_mm);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/homography_query_arbiter.md
# homography_query_arbiter

Shares the single homography lookup engine between two coordinate requesters (requester 0: DVI pixel stream, requester 1: CCD pixel stream). It issues round-robin queries, bounds the number of in-flight queries with a credit counter, and records the issuing requester in an in-order tag FIFO. Each engine return is routed back to its owner. It sits between the pixel-stream front ends and the homography engine, upstream of the output sync/merge stage.

## Interface
- MAX_OUTSTANDING, 5, maximum in-flight engine queries; legal range 1..7
- clk_25  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- req0_valid / req1_valid  in  1  requester has a query pending; hold until granted
- req0_x / req1_x  in  10  query x coordinate
- req0_y / req1_y  in  10  query y coordinate
- req0_grant / req1_grant  out  1  combinational; query accepted this cycle
- flush  in  1  level; stop issuing and drain all outstanding queries
- flush_done  out  1  one-cycle pulse when the drain completes
- query_x / query_y  out  10  registered query coordinates to the engine
- start  out  1  one-cycle pulse per query
- ready  in  1  engine return valid, one cycle per return
- return_x / return_y  in  10  coordinates echoed by the engine
- r / g / b  in  5/6/5  RGB565 result
- resp0_val / resp1_val  out  1  registered response strobe for each requester
- resp_x / resp_y  out  10  coordinates of the response
- resp_r / resp_g / resp_b  out  5/6/5  response colour
- outstanding  out  3  current in-flight count
- err_underflow  out  1  sticky; a return arrived with no outstanding query
- mismatch  out  1  sticky; return coordinates differed from the issued ones (driven only under the macro)

## Operation
- States: S_IDLE (outstanding==0), S_RUN (0<outstanding<MAX), S_FULL (outstanding==MAX), S_DRAIN (flush seen, outstanding>0).
- Issue is allowed in S_IDLE/S_RUN when flush==0. Eligibility is based on the registered count only: no issue in S_FULL, even if a return arrives in the same cycle.
- Arbitration: if one requester is valid, grant it. If both are valid, grant the one not granted last. last_grant resets to 1, so req0 wins the first tie.
- On grant:
  - query_x/y ← granted coords.
  - start=1 on the next cycle.
  - Push the tag {owner, x, y} into the FIFO.
  - outstanding +1.
- On ready:
  - Pop the tag.
  - Next cycle: resp{owner}_val=1, resp_x/y = return_x/y, resp_r/g/b = r/g/b.
  - outstanding −1.
- Grant and ready in the same cycle: push and pop both happen, outstanding is unchanged.
- ready with an empty FIFO: response dropped (no val), err_underflow set, outstanding stays 0.
- flush:
  - Any state with flush=1 and outstanding>0 → S_DRAIN. No grants in S_DRAIN.
  - When the last return pops, pulse flush_done and go to S_IDLE.
  - flush=1 with outstanding==0 pulses flush_done on the next cycle.
  - Issue resumes the cycle after flush deasserts.
- Transitions: S_IDLE→S_RUN on grant; S_RUN→S_FULL when the count reaches MAX; S_FULL→S_RUN on return; S_RUN→S_IDLE when the count reaches 0.

## Timing
- Reset values: all outputs 0, FIFO empty, outstanding 0, state S_IDLE, sticky flags cleared.
- Reset mid-operation discards all tags. Returns arriving after reset flag err_underflow.
- Grant→start latency: 1 cycle. ready→resp_val latency: 1 cycle.
- A single requester with valid held high gets at most one grant per cycle.
- start never pulses in S_FULL or S_DRAIN.
- outstanding never exceeds MAX_OUTSTANDING and never wraps below 0.

## Configuration
- HQA_COORD_CHECK_EN defined:
  - FIFO entries carry the issued x/y (21 bits each).
  - On every pop, if return_x/y ≠ stored x/y, mismatch sets and stays set until reset.
- HQA_COORD_CHECK_EN undefined:
  - FIFO stores only the 1-bit owner.
  - mismatch is tied 0.
  - Routing is unchanged.

## Structure
- Package hqa_pkg holds:
  - state enum (S_IDLE, S_RUN, S_FULL, S_DRAIN)
  - COORD_W=10
  - R_W=5, G_W=6, B_W=5
  - the tag struct type
- Sub-module hqa_tag_fifo: synchronous FIFO of depth MAX_OUTSTANDING with push, pop, full, empty. It supports simultaneous push and pop when not empty.

## Test plan
- req0 only, (12,34), engine returns 3 cycles later → start one cycle after grant; resp0_val pulse with resp_x=12, resp_y=34; resp1_val stays 0.
- Both requesters valid for 6 cycles, engine returns held off → grants alternate 0,1,0,1,0; state S_FULL; outstanding=5; no 6th start.
- Full state, then one ready → outstanding 4; next cycle grant resumes with req1 (round-robin continues).
- Grant and ready in the same cycle with outstanding=2 → outstanding stays 2; response routed to the owner of the oldest tag.
- flush with 3 outstanding → no grants; flush_done pulses exactly one cycle after the third response strobe.
- ready with FIFO empty → no resp strobe; err_underflow=1. With the macro, a return of (5,6) against issued (5,7) → mismatch=1.
